led_response_checker: RTL and testbench

- On-board hardware counterpart of the lab switch-stimulus benches.
- Plays a fixed table of 10-bit switch vectors into a DUT's SW input and samples the DUT's LEDR response at a fixed point after each vector is applied.
- Compares each sample against an expected-value table and reports pass/fail and the mismatch count.
- Sits between board-level glue (CLOCK_50, KEY-derived start, LEDR/HEX display) and the lab DUT, so the DUT can be checked without a simulator.

---
 rtl/led_check_pkg.sv | 37 +++
 rtl/led_vector_rom.sv | 13 +
 rtl/led_response_checker.sv | 161 ++++++++++++++++
 tb/tb_led_response_checker.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/led_check_pkg.sv
// Shared definitions for the LED response checker: FSM encoding, vector width and vector tables.
package led_check_pkg;

  localparam int VEC_W = 10;
  localparam int IDX_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    HOLD,
    DONE
  } state_t;

  function automatic logic [VEC_W-1:0] stim_entry(input logic [IDX_W-1:0] idx);
    logic [VEC_W-1:0] v;
    case (idx)
      4'd0:    v = 10'h000;
      4'd1:    v = 10'h001;
      4'd2:    v = 10'h042;
      4'd3:    v = 10'h175;
      4'd4:    v = 10'h1BA;
      4'd5:    v = 10'h200;
      4'd6:    v = 10'h0AE;
      4'd7:    v = 10'h3FF;
      default: v = 10'h000;
    endcase
    return v;
  endfunction

  // The reference lab DUT echoes SW straight onto LEDR.
  function automatic logic [VEC_W-1:0] exp_entry(input logic [IDX_W-1:0] idx);
    return stim_entry(idx);
  endfunction

endpackage

// File: rtl/led_vector_rom.sv
// Combinational lookup of the stimulus vector and its expected LEDR response by index.
module led_vector_rom
  import led_check_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [VEC_W-1:0] stim,
  output logic [VEC_W-1:0] exp_val
);

  assign stim    = stim_entry(idx);
  assign exp_val = exp_entry(idx);

endmodule

// File: rtl/led_response_checker.sv
// Plays the vector table into a lab DUT, samples LEDR SETTLE_CYCLES+1 cycles after each vector, counts mismatches.
// Optional first-mismatch capture outputs exist only when LED_CHECK_FIRST_FAIL_EN is defined.
module led_response_checker
  import led_check_pkg::*;
#(
  parameter int NUM_VEC       = 8,
  parameter int HOLD_CYCLES   = 20,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             CLOCK_50,
  input  logic             RST,
  input  logic             start,
  output logic [VEC_W-1:0] stim_out,
  input  logic [VEC_W-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [4:0]       fail_count,
  output logic [IDX_W-1:0] vec_index
`ifdef LED_CHECK_FIRST_FAIL_EN
  ,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic [VEC_W-1:0] first_fail_resp,
  output logic             first_fail_valid
`endif
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  // Counter starts at 0 on the first cycle after APPLY, so HOLD_CYCLES-2 marks the last cycle of a vector.
  localparam logic [CNT_W-1:0] VEC_LAST    = CNT_W'(HOLD_CYCLES - 2);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_VEC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VEC_W-1:0] stim_q, stim_d;
  logic [VEC_W-1:0] resp_q;
  logic [4:0]       fail_q, fail_d;
  logic [VEC_W-1:0] rom_stim, rom_exp;
  logic             mismatch;

`ifdef LED_CHECK_FIRST_FAIL_EN
  logic [IDX_W-1:0] ff_idx_q, ff_idx_d;
  logic [VEC_W-1:0] ff_resp_q, ff_resp_d;
  logic             ff_vld_q, ff_vld_d;
`endif

  led_vector_rom u_rom (
    .idx     (idx_q),
    .stim    (rom_stim),
    .exp_val (rom_exp)
  );

  assign mismatch = (resp_q != rom_exp);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stim_d  = stim_q;
    fail_d  = fail_q;
`ifdef LED_CHECK_FIRST_FAIL_EN
    ff_idx_d  = ff_idx_q;
    ff_resp_d = ff_resp_q;
    ff_vld_d  = ff_vld_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = APPLY;
          idx_d   = '0;
          fail_d  = '0;
`ifdef LED_CHECK_FIRST_FAIL_EN
          ff_idx_d  = '0;
          ff_resp_d = '0;
          ff_vld_d  = 1'b0;
`endif
        end
      end
      APPLY: begin
        stim_d  = rom_stim;
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
      end
      SAMPLE, HOLD: begin
        cnt_d = cnt_q + CNT_ONE;
        if (state_q == SAMPLE) begin
          state_d = HOLD;
          if (mismatch) begin
            if (fail_q != 5'd31) fail_d = fail_q + 5'd1;
`ifdef LED_CHECK_FIRST_FAIL_EN
            if (!ff_vld_q) begin
              ff_idx_d  = idx_q;
              ff_resp_d = resp_q;
              ff_vld_d  = 1'b1;
            end
`endif
          end
        end
        if (cnt_q == VEC_LAST) begin
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = APPLY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stim_q  <= '0;
      resp_q  <= '0;
      fail_q  <= '0;
`ifdef LED_CHECK_FIRST_FAIL_EN
      ff_idx_q  <= '0;
      ff_resp_q <= '0;
      ff_vld_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stim_q  <= stim_d;
      resp_q  <= resp_in;
      fail_q  <= fail_d;
`ifdef LED_CHECK_FIRST_FAIL_EN
      ff_idx_q  <= ff_idx_d;
      ff_resp_q <= ff_resp_d;
      ff_vld_q  <= ff_vld_d;
`endif
    end
  end

  assign stim_out   = stim_q;
  assign vec_index  = idx_q;
  assign fail_count = fail_q;
  assign busy       = (state_q == APPLY) || (state_q == SETTLE) ||
                      (state_q == SAMPLE) || (state_q == HOLD);
  assign done       = (state_q == DONE);
  assign pass       = (state_q == DONE) && (fail_q == 5'd0);

`ifdef LED_CHECK_FIRST_FAIL_EN
  assign first_fail_idx   = ff_idx_q;
  assign first_fail_resp  = ff_resp_q;
  assign first_fail_valid = ff_vld_q;
`endif

endmodule

// File: tb/tb_led_response_checker.sv
// Bench for led_response_checker: directed runs against identity, stuck-bit and delayed DUT models.
module tb_led_response_checker;

  logic       CLOCK_50 = 1'b0;
  logic       RST      = 1'b1;
  logic       start    = 1'b0;
  logic [9:0] stim_out, resp_in, stim4, resp4;
  logic       busy, done, pass, busy4, done4, pass4;
  logic [4:0] fail_count, fail4;
  logic [3:0] vec_index, vidx4;
`ifdef LED_CHECK_FIRST_FAIL_EN
  logic [3:0] ff_idx, ff_idx4;
  logic [9:0] ff_resp, ff_resp4;
  logic       ff_vld, ff_vld4;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   mode    = 0;   // 0 identity, 1 bit0 stuck at 0, 2 three-cycle delay
  logic [9:0] d1 = '0, d2 = '0, d3 = '0;
  logic [9:0] e1 = '0, e2 = '0, e3 = '0;
  logic       done_prev = 1'b0;

  typedef struct {
    logic [4:0] fc;
    logic       ps;
    logic       ffv;
    logic [3:0] ffi;
    logic [9:0] ffr;
  } exp_t;
  exp_t exp_q[$];

  logic [9:0] stim_tab [8] = '{10'h000, 10'h001, 10'h042, 10'h175,
                               10'h1BA, 10'h200, 10'h0AE, 10'h3FF};

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    d1 <= stim_out; d2 <= d1; d3 <= d2;
    e1 <= stim4;    e2 <= e1; e3 <= e2;
  end

  assign resp_in = (mode == 0) ? stim_out :
                   (mode == 1) ? {stim_out[9:1], 1'b0} : d3;
  assign resp4   = e3;

  led_response_checker u_dut (
    .CLOCK_50 (CLOCK_50), .RST (RST), .start (start),
    .stim_out (stim_out), .resp_in (resp_in),
    .busy (busy), .done (done), .pass (pass),
    .fail_count (fail_count), .vec_index (vec_index)
`ifdef LED_CHECK_FIRST_FAIL_EN
    , .first_fail_idx (ff_idx), .first_fail_resp (ff_resp), .first_fail_valid (ff_vld)
`endif
  );

  led_response_checker #(.NUM_VEC(8), .HOLD_CYCLES(20), .SETTLE_CYCLES(4)) u_dut4 (
    .CLOCK_50 (CLOCK_50), .RST (RST), .start (start),
    .stim_out (stim4), .resp_in (resp4),
    .busy (busy4), .done (done4), .pass (pass4),
    .fail_count (fail4), .vec_index (vidx4)
`ifdef LED_CHECK_FIRST_FAIL_EN
    , .first_fail_idx (ff_idx4), .first_fail_resp (ff_resp4), .first_fail_valid (ff_vld4)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stim"}, 32'(stim_out), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_fc"},   32'(fail_count), 0);
    chk({tag, "_vidx"}, 32'(vec_index), 0);
  endtask

  task automatic do_reset();
    @(posedge CLOCK_50); #1 RST = 1'b1;
    @(posedge CLOCK_50); #1 RST = 1'b0;
  endtask

  task automatic push_exp(input logic [4:0] fc, input logic ps, input logic ffv,
                          input logic [3:0] ffi, input logic [9:0] ffr);
    exp_t e;
    e.fc = fc; e.ps = ps; e.ffv = ffv; e.ffi = ffi; e.ffr = ffr;
    exp_q.push_back(e);
  endtask

  // Pulses start, then follows the run until done or an abort; optional restart pulse while busy.
  task automatic run_vec(input string tag, input bit trace, input int restart_at,
                         input int abort_at, input logic [4:0] abort_fc);
    int cycles;
    @(posedge CLOCK_50); #1 start = 1'b1;
    @(posedge CLOCK_50); #1 start = 1'b0;
    chk({tag, "_busy_at_start"}, 32'(busy), 1);
    chk({tag, "_fc_cleared"}, 32'(fail_count), 0);
    cycles = 0;
    while (!done && cycles < 400) begin
      @(posedge CLOCK_50); #1;
      cycles++;
      start = 1'b0;
      if (cycles == restart_at) start = 1'b1;
      if (trace && (cycles % 20 == 10)) begin
        chk({tag, "_stim_out"}, 32'(stim_out), 32'(stim_tab[cycles / 20]));
        chk({tag, "_vec_index"}, 32'(vec_index), 32'(cycles / 20));
      end
      if (cycles == abort_at) begin
        chk({tag, "_fc_before_abort"}, 32'(fail_count), 32'(abort_fc));
        RST = 1'b1;
        @(posedge CLOCK_50); #1 RST = 1'b0;
        chk_reset_vals({tag, "_abort"});
        return;
      end
    end
    chk({tag, "_run_length"}, 32'(cycles), 160);
  endtask

  // Scoreboard monitor: compares each completed run against the queued expectation.
  always @(negedge CLOCK_50) begin
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_done", 32'(done), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_fail_count", 32'(fail_count), 32'(e.fc));
        chk("sb_pass", 32'(pass), 32'(e.ps));
        chk("sb_busy_low", 32'(busy), 0);
`ifdef LED_CHECK_FIRST_FAIL_EN
        chk("sb_ff_valid", 32'(ff_vld), 32'(e.ffv));
        chk("sb_ff_idx", 32'(ff_idx), 32'(e.ffi));
        chk("sb_ff_resp", 32'(ff_resp), 32'(e.ffr));
`endif
      end
    end
    done_prev <= done;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge CLOCK_50);
    #1 RST = 1'b0;
    chk_reset_vals("reset");

    // start and RST together: reset wins, checker stays idle
    @(posedge CLOCK_50); #1 start = 1'b1; RST = 1'b1;
    @(posedge CLOCK_50); #1 start = 1'b0; RST = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("start_rst_busy", 32'(busy), 0);
    chk("start_rst_done", 32'(done), 0);

    mode = 0;
    push_exp(5'd0, 1'b1, 1'b0, 4'd0, 10'h000);
    run_vec("identity", 1'b1, -1, -1, 5'd0);

    push_exp(5'd0, 1'b1, 1'b0, 4'd0, 10'h000);
    run_vec("start_while_busy", 1'b0, 50, -1, 5'd0);

    mode = 1;
    push_exp(5'd3, 1'b0, 1'b1, 4'd1, 10'h000);
    run_vec("bit0_stuck", 1'b0, -1, -1, 5'd0);

    mode = 0;
    push_exp(5'd0, 1'b1, 1'b0, 4'd0, 10'h000);
    run_vec("restart_from_done", 1'b0, -1, -1, 5'd0);

    mode = 1;
    run_vec("abort_mid_hold", 1'b0, -1, 90, 5'd2);

    mode = 0;
    push_exp(5'd0, 1'b1, 1'b0, 4'd0, 10'h000);
    run_vec("after_abort", 1'b1, -1, -1, 5'd0);

    // Delay model needs a fresh start from stim_out=0 so vector 0 is not stale.
    mode = 2;
    do_reset();
    repeat (5) @(posedge CLOCK_50);
    push_exp(5'd7, 1'b0, 1'b1, 4'd1, 10'h000);
    run_vec("delay_settle2", 1'b0, -1, -1, 5'd0);
    chk("delay_settle4_done", 32'(done4), 1);
    chk("delay_settle4_fc", 32'(fail4), 0);
    chk("delay_settle4_pass", 32'(pass4), 1);

    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("sb_all_runs_seen", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
